load_store_unit: RTL and testbench

Sequencer between the core's execute stage and the byte-addressable `Memory` block. Accepts one load/store request at a time over a valid/ready handshake and drives `Memory`'s address, write-data, write-enable and write-length inputs. For loads it captures `Memory`'s combinational read word and returns it byte- or halfword-extended per the RISC-V funct3. Illegal funct3 encodings are rejected with an error response and never reach memory.

---
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between the execute stage and the
// byte-addressable Memory block, with RISC-V load extension and funct3 checking.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_enable,
    output logic [2:0]  mem_write_length,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state_reg;
    logic        store_reg;
    logic        legal_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        error_reg;

    logic        req_legal;
    logic [31:0] load_ext;

    // Stores accept 000/001/010; loads additionally accept 100/101.
    always_comb begin
        if (req_store) begin
            req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
        end else begin
            req_legal = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
        end
    end

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b001:  load_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b100:  load_ext = {24'd0, mem_read_data[7:0]};
            3'b101:  load_ext = {16'd0, mem_read_data[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            store_reg  <= 1'b0;
            legal_reg  <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            rdata_reg  <= 32'd0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        store_reg  <= req_store;
                        legal_reg  <= req_legal;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        state_reg  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Response fields are loaded here and held until the next access.
                    if (!legal_reg) begin
                        rdata_reg <= 32'd0;
                        error_reg <= 1'b1;
                    end else if (store_reg) begin
                        rdata_reg <= 32'd0;
                        error_reg <= 1'b0;
                    end else begin
                        rdata_reg <= load_ext;
                        error_reg <= 1'b0;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready        = rst_n && (state_reg == IDLE);
    assign resp_valid       = (state_reg == RESP);
    assign resp_rdata       = rdata_reg;
    assign resp_error       = error_reg;
    assign mem_address      = addr_reg;
    assign mem_wr_data      = wdata_reg;
    assign mem_write_length = {1'b0, funct3_reg[1:0]};
    // Gated by rst_n so a reset landing on ACCESS never commits the write.
    assign mem_wr_enable    = rst_n && (state_reg == ACCESS) && store_reg && legal_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit: a byte-array Memory model,
// a byte-level reference model and a scoreboard checked by a separate monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic        mem_wr_enable;
    logic [2:0]  mem_write_length;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_wr_data      (mem_wr_data),
        .mem_wr_enable    (mem_wr_enable),
        .mem_write_length (mem_write_length),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory block: 1 KiB, byte addressed with wrap, combinational little-endian read.
    logic [7:0] mem [0:1023] = '{default: 8'h00};

    assign mem_read_data = {mem[10'(mem_address + 32'd3)], mem[10'(mem_address + 32'd2)],
                            mem[10'(mem_address + 32'd1)], mem[10'(mem_address)]};

    always @(posedge clk) begin
        if (mem_wr_enable) begin
            for (int i = 0; i < (1 << mem_write_length); i++) begin
                mem[10'(mem_address + 32'(i))] <= mem_wr_data[8*i +: 8];
            end
        end
    end

    // Reference model state, advanced at issue time since requests are serialized.
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        w = 32'd0;
        for (int i = 0; i < 4; i++) w = w + (32'(ref_mem[10'(a + 32'(i))]) << (8 * i));
        b = w % 256;
        h = w % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int nbytes;
        nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) ref_mem[10'(a + 32'(i))] = 8'((d >> (8 * i)) % 256);
    endtask

    // Monitor: one line per observed response.
    always @(negedge clk) begin
        if (mem_wr_enable) begin
            if (wr_q.size() == 0) begin
                chk("spurious_write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", mem_address, w.addr);
                chk("wr_data", mem_wr_data, w.data);
                chk("wr_len", {29'd0, mem_write_length}, {29'd0, w.len});
            end
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                $display("resp cycle %0d rdata %h error %0b", cyc, resp_rdata, resp_error);
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("resp_error", {31'd0, resp_error}, {31'd0, r.err});
                chk("resp_latency", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep_valid, input bit expect_resp,
                         output int acc);
        int guard;
        resp_t r;
        wr_t w;
        guard = 0;
        acc = -1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL handshake: req_ready stuck at %0b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        if (expect_resp) begin
            r.err = !is_legal(st, f3);
            r.cyc = acc + 1;
            r.rdata = 32'd0;
            if (!r.err) begin
                if (st) begin
                    w.addr = a;
                    w.data = wd;
                    w.len = {1'b0, f3[1:0]};
                    wr_q.push_back(w);
                    ref_store(a, f3, wd);
                end else begin
                    r.rdata = ref_load(a, f3);
                end
            end
            resp_q.push_back(r);
        end
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        $display("req st=%0b f3=%0d addr=%h wdata=%h accepted cycle %0d", st, f3, a, wd, acc);
    endtask

    task automatic go(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
        int acc;
        issue(st, f3, a, wd, 1'b0, 1'b1, acc);
    endtask

    int a1, a2, a3;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready_low", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wr_enable", {31'd0, mem_wr_enable}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        // SW then LW, misaligned
        go(1'b1, 3'd2, 32'd5, 32'h12345678);
        go(1'b0, 3'd2, 32'd5, 32'd0);
        // byte stores into one word
        go(1'b1, 3'd0, 32'd4, 32'h12ABCDEF);
        go(1'b1, 3'd0, 32'd5, 32'h34FBDEAD);
        go(1'b1, 3'd0, 32'd6, 32'h56EDFABD);
        go(1'b1, 3'd0, 32'd7, 32'h78ADEFAB);
        go(1'b0, 3'd2, 32'd4, 32'd0);
        // halfword overlay and all load extensions
        go(1'b1, 3'd2, 32'd36, 32'h1234ABCD);
        go(1'b1, 3'd1, 32'd36, 32'h5678EFDA);
        go(1'b0, 3'd2, 32'd36, 32'd0);
        go(1'b0, 3'd1, 32'd36, 32'd0);
        go(1'b0, 3'd5, 32'd36, 32'd0);
        go(1'b0, 3'd0, 32'd38, 32'd0);
        go(1'b0, 3'd0, 32'd36, 32'd0);
        go(1'b0, 3'd4, 32'd36, 32'd0);
        // illegal encodings must not touch memory
        go(1'b0, 3'd3, 32'd36, 32'd0);
        go(1'b1, 3'd4, 32'd36, 32'hFFFFFFFF);
        go(1'b1, 3'd3, 32'd36, 32'hFFFFFFFF);
        go(1'b0, 3'd2, 32'd36, 32'd0);

        // req_valid held across three stores
        issue(1'b1, 3'd2, 32'd100, 32'hA1A2A3A4, 1'b1, 1'b1, a1);
        issue(1'b1, 3'd2, 32'd104, 32'hB1B2B3B4, 1'b1, 1'b1, a2);
        issue(1'b1, 3'd2, 32'd108, 32'hC1C2C3C4, 1'b0, 1'b1, a3);
        chk("accept_spacing_1", 32'(a2 - a1), 32'd3);
        chk("accept_spacing_2", 32'(a3 - a2), 32'd3);
        go(1'b0, 3'd2, 32'd104, 32'd0);

        // reset during ACCESS drops the store
        go(1'b1, 3'd2, 32'd8, 32'h11223344);
        issue(1'b1, 3'd2, 32'd8, 32'hDEADBEEF, 1'b0, 1'b0, a1);
        rst_n = 1'b0;
        #1;
        chk("rst_access_wr_enable", {31'd0, mem_wr_enable}, 32'd0);
        chk("rst_access_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_rst_mem_address", mem_address, 32'd0);
        chk("post_rst_mem_wr_data", mem_wr_data, 32'd0);
        chk("post_rst_mem_len", {29'd0, mem_write_length}, 32'd0);
        chk("post_rst_resp_rdata", resp_rdata, 32'd0);
        chk("post_rst_resp_error", {31'd0, resp_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        go(1'b0, 3'd2, 32'd8, 32'd0);

        // random mix of legal and illegal requests
        for (int n = 0; n < 80; n++) begin
            int acc;
            logic st;
            logic [2:0] f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            issue(st, f3, a, $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
        end
        req_valid = 1'b0;

        for (int i = 0; i < 20 && (resp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
